hazard_scoreboard: RTL

Producer-side hazard tracker for the MIPS pipeline. It records every register write as the instruction leaves ID, and clears the record when that write retires at WB. It raises `stall` to hold PC/IF-ID and inject an EX bubble whenever EX/MEM/WB bypassing cannot yet supply an operand the ID instruction needs. It also covers load-use hazards, the multi-cycle non-pipelined multiplier, and WAW saturation.

---
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer-side RAW/WAW hazard tracker for the MIPS pipeline.
// Records register writes as they leave ID, clears them at WB retire, and raises
// stall when bypassing cannot yet supply an ID operand (load-use, multiplier
// results, busy multiplier, or too many in-flight writes to one register).
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_scoreboard #(
    parameter int MUL_LATENCY = 4,
    parameter int MAX_PEND    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_valid,
    input  logic        ID_flush,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_uses_Rs,
    input  logic        ID_uses_Rt,
    input  logic        ID_reg_write,
    input  logic [4:0]  ID_Rd,
    input  logic        ID_is_load,
    input  logic        ID_is_mul,
    input  logic        WB_reg_write,
    input  logic [4:0]  WB_Rd,
    output logic        stall,
    output logic [31:0] stall_cycles
);

    localparam logic [2:0] MUL_RDY      = 3'(MUL_LATENCY - 1);
    localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LATENCY);
    localparam logic [1:0] PEND_MAX     = 2'(MAX_PEND);

    // Entry 0 exists only so a 5-bit index is always in range; it is never written.
    logic [1:0] pend_q [32];
    logic [1:0] pend_d [32];
    logic [2:0] rdy_q  [32];
    logic [2:0] rdy_d  [32];
    logic [2:0] mul_cnt_q, mul_cnt_d;

    logic hz_rs, hz_rt, hz_mul, hz_waw;
    logic issue, issue_wr, retire, collide;

    // Hazard detection: purely combinational from current records and ID fields.
    always_comb begin
        hz_rs  = ID_uses_Rs && (ID_Rs != 5'd0) && (pend_q[ID_Rs] != 2'd0) && (rdy_q[ID_Rs] != 3'd0);
        hz_rt  = ID_uses_Rt && (ID_Rt != 5'd0) && (pend_q[ID_Rt] != 2'd0) && (rdy_q[ID_Rt] != 3'd0);
        hz_mul = ID_is_mul && (mul_cnt_q > 3'd1);
        hz_waw = ID_reg_write && (ID_Rd != 5'd0) && (pend_q[ID_Rd] == PEND_MAX);
        stall  = ID_valid && !ID_flush && (hz_rs || hz_rt || hz_mul || hz_waw);
        issue    = ID_valid && !ID_flush && !stall;
        issue_wr = issue && ID_reg_write && (ID_Rd != 5'd0);
        retire   = WB_reg_write && (WB_Rd != 5'd0) && (pend_q[WB_Rd] != 2'd0);
        collide  = issue_wr && retire && (ID_Rd == WB_Rd);
    end

    // Next-state: age readiness, record new writes, retire completed writes.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            rdy_d[r]  = (rdy_q[r] != 3'd0) ? rdy_q[r] - 3'd1 : 3'd0;
        end
        mul_cnt_d = (mul_cnt_q != 3'd0) ? mul_cnt_q - 3'd1 : 3'd0;

        if (issue_wr) begin
            if (ID_is_mul)
                rdy_d[ID_Rd] = MUL_RDY;
            else if (ID_is_load)
                rdy_d[ID_Rd] = 3'd1;
            else
                rdy_d[ID_Rd] = 3'd0;
            // An issue and a retire to the same register cancel out.
            if (!collide)
                pend_d[ID_Rd] = pend_q[ID_Rd] + 2'd1;
        end

        if (issue && ID_is_mul)
            mul_cnt_d = MUL_CNT_INIT;

        if (retire && !collide)
            pend_d[WB_Rd] = pend_q[WB_Rd] - 2'd1;
    end

    // State registers; reset discards every in-flight record.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= 2'd0;
                rdy_q[r]  <= 3'd0;
            end
            mul_cnt_q <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= pend_d[r];
                rdy_q[r]  <= rdy_d[r];
            end
            mul_cnt_q <= mul_cnt_d;
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Free-running stall counter, wraps modulo 2^32.
    always_comb begin
        stall_cycles_d = stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_q <= 32'd0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
